crc_err_rsp_sched: RTL and testbench

Error-response record buffer and presentation scheduler for the CRC engine. Captures error records pushed by the CRC datapath into a DEPTH-entry FIFO. Presents the oldest record to the CRC register block one at a time through a single-cycle load strobe, then waits for a firmware POP before presenting the next. Drives the error-FIFO-full interrupt level consumed by the interrupt status logic.

---
 rtl/crc_err_pkg.sv | 31 +++
 rtl/crc_err_fifo_mem.sv | 61 ++++++
 rtl/crc_err_rsp_sched.sv | 103 ++++++++++
 tb/tb_crc_err_rsp_sched.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_err_pkg.sv
// Shared types for the CRC error-response buffer: the record layout, field widths
// and scheduler state encoding.
package crc_err_pkg;

  localparam int ERR_CODE_W = 8;
  localparam int POLY_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int SIZE_SEL_W = 2;
  localparam int RPT_NUM_W  = 3;
  localparam int REQ_ID_W   = 16;

  // 157-bit error record; field order is also the presentation order.
  typedef struct packed {
    logic [ERR_CODE_W-1:0] err_rsp_code;
    logic [POLY_W-1:0]     poly_lsb;
    logic [POLY_W-1:0]     poly_msb;
    logic [ADDR_W-1:0]     data_addr;
    logic [ADDR_W-1:0]     crc_addr;
    logic [SIZE_SEL_W-1:0] poly_size_sel;
    logic [RPT_NUM_W-1:0]  rpt_num;
    logic [REQ_ID_W-1:0]   req_id;
  } crc_err_rec_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    WAIT_POP = 2'd2,
    CLR      = 2'd3
  } crc_err_sched_state_e;

endpackage

// File: rtl/crc_err_fifo_mem.sv
// Record FIFO for the error-response scheduler: storage, wrapping pointers,
// occupancy count and full/empty flags derived from the registered count.
module crc_err_fifo_mem
  import crc_err_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  crc_err_rec_t                 push_rec_i,
  input  logic                         pop_i,
  output crc_err_rec_t                 head_rec_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  crc_err_rec_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;

  // NOTE: storage has no reset; the pointers and count alone decide which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_rec_i;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i) begin
      count_d = count_q + CW'(1);
    end else if (!push_i && pop_i) begin
      count_d = count_q - CW'(1);
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  assign head_rec_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);

endmodule

// File: rtl/crc_err_rsp_sched.sv
// Error-response scheduler: buffers records from the CRC datapath and presents the
// oldest one to the register block, waiting for a firmware POP before the next.
module crc_err_rsp_sched
  import crc_err_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                         i_sys_clk,
  input  logic                         i_sys_arstn,
  input  logic                         i_push_valid,
  output logic                         o_push_ready,
  input  logic [ERR_CODE_W-1:0]        i_push_err_rsp_code,
  input  logic [POLY_W-1:0]            i_push_poly_lsb,
  input  logic [POLY_W-1:0]            i_push_poly_msb,
  input  logic [ADDR_W-1:0]            i_push_data_addr,
  input  logic [ADDR_W-1:0]            i_push_crc_addr,
  input  logic [SIZE_SEL_W-1:0]        i_push_poly_size_sel,
  input  logic [RPT_NUM_W-1:0]         i_push_rpt_num,
  input  logic [REQ_ID_W-1:0]          i_push_req_id,
  output logic [ERR_CODE_W-1:0]        o_crc_err_fifo_pop_err_rsp_code_next,
  output logic [POLY_W-1:0]            o_crc_err_fifo_data0_poly_lsb_next,
  output logic [POLY_W-1:0]            o_crc_err_fifo_data1_poly_msb_next,
  output logic [ADDR_W-1:0]            o_crc_err_fifo_data2_data_addr_next,
  output logic [ADDR_W-1:0]            o_crc_err_fifo_data3_crc_addr_next,
  output logic [SIZE_SEL_W-1:0]        o_crc_err_fifo_data4_poly_size_sel_next,
  output logic [RPT_NUM_W-1:0]         o_crc_err_fifo_data4_rpt_num_next,
  output logic [REQ_ID_W-1:0]          o_crc_err_fifo_data4_crc_req_id_next,
  output logic                         o_crc_err_fifo_pop_valid_wr_enable,
  input  logic                         i_crc_err_fifo_pop_pop,
  output logic                         o_err_fifo_pop_clr,
  output logic                         o_crc_err_rsp_full_int_lvl,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  crc_err_sched_state_e state_q, state_d;
  crc_err_rec_t         push_rec, head_rec, pres_q;
  logic                 pop_q, pop_rise, push_fire, load;
  logic                 fifo_full, fifo_empty;

  assign push_rec = '{err_rsp_code:  i_push_err_rsp_code,
                      poly_lsb:      i_push_poly_lsb,
                      poly_msb:      i_push_poly_msb,
                      data_addr:     i_push_data_addr,
                      crc_addr:      i_push_crc_addr,
                      poly_size_sel: i_push_poly_size_sel,
                      rpt_num:       i_push_rpt_num,
                      req_id:        i_push_req_id};

  assign push_fire = i_push_valid & ~fifo_full;
  assign load      = (state_q == IDLE) & ~fifo_empty;
  // Edges seen outside WAIT_POP are consumed by pop_q and never pop a record.
  assign pop_rise  = i_crc_err_fifo_pop_pop & ~pop_q;

  crc_err_fifo_mem #(.DEPTH(DEPTH)) u_fifo (
    .clk_i      (i_sys_clk),
    .rst_ni     (i_sys_arstn),
    .push_i     (push_fire),
    .push_rec_i (push_rec),
    .pop_i      (load),
    .head_rec_o (head_rec),
    .count_o    (o_count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (!fifo_empty) state_d = LOAD;
      LOAD:     state_d = WAIT_POP;
      WAIT_POP: if (pop_rise) state_d = CLR;
      CLR:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_arstn) begin
      state_q <= IDLE;
      pop_q   <= 1'b0;
      pres_q  <= '0;
    end else begin
      state_q <= state_d;
      pop_q   <= i_crc_err_fifo_pop_pop;
      if (load) pres_q <= head_rec;
    end
  end

  assign o_push_ready                       = ~fifo_full;
  assign o_crc_err_rsp_full_int_lvl         = fifo_full;
  assign o_crc_err_fifo_pop_valid_wr_enable = (state_q == LOAD);
  assign o_err_fifo_pop_clr                 = (state_q == CLR);

  assign o_crc_err_fifo_pop_err_rsp_code_next    = pres_q.err_rsp_code;
  assign o_crc_err_fifo_data0_poly_lsb_next      = pres_q.poly_lsb;
  assign o_crc_err_fifo_data1_poly_msb_next      = pres_q.poly_msb;
  assign o_crc_err_fifo_data2_data_addr_next     = pres_q.data_addr;
  assign o_crc_err_fifo_data3_crc_addr_next      = pres_q.crc_addr;
  assign o_crc_err_fifo_data4_poly_size_sel_next = pres_q.poly_size_sel;
  assign o_crc_err_fifo_data4_rpt_num_next       = pres_q.rpt_num;
  assign o_crc_err_fifo_data4_crc_req_id_next    = pres_q.req_id;

endmodule

// File: tb/tb_crc_err_rsp_sched.sv
// Bench for crc_err_rsp_sched: random records checked against an in-order queue
// model, plus directed timing scenarios for load, pop, full and reset behaviour.
module tb_crc_err_rsp_sched;
  import crc_err_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH+1);

  logic          i_sys_clk = 1'b0;
  logic          i_sys_arstn;
  logic          push_valid;
  crc_err_rec_t  push_data;
  logic          pop;
  logic          o_push_ready;
  logic [ERR_CODE_W-1:0] o_code;
  logic [POLY_W-1:0]     o_poly_lsb, o_poly_msb;
  logic [ADDR_W-1:0]     o_data_addr, o_crc_addr;
  logic [SIZE_SEL_W-1:0] o_size_sel;
  logic [RPT_NUM_W-1:0]  o_rpt_num;
  logic [REQ_ID_W-1:0]   o_req_id;
  logic          o_strobe, o_clr, o_full;
  logic [CW-1:0] o_count;
  crc_err_rec_t  got;

  int n_checks = 0;
  int n_fail   = 0;
  int n_push, n_load, n_clr;
  crc_err_rec_t exp_q[$];
  crc_err_rec_t exp_rec;

  always #5 i_sys_clk = ~i_sys_clk;

  crc_err_rsp_sched #(.DEPTH(DEPTH)) dut (
    .i_sys_clk                               (i_sys_clk),
    .i_sys_arstn                             (i_sys_arstn),
    .i_push_valid                            (push_valid),
    .o_push_ready                            (o_push_ready),
    .i_push_err_rsp_code                     (push_data.err_rsp_code),
    .i_push_poly_lsb                         (push_data.poly_lsb),
    .i_push_poly_msb                         (push_data.poly_msb),
    .i_push_data_addr                        (push_data.data_addr),
    .i_push_crc_addr                         (push_data.crc_addr),
    .i_push_poly_size_sel                    (push_data.poly_size_sel),
    .i_push_rpt_num                          (push_data.rpt_num),
    .i_push_req_id                           (push_data.req_id),
    .o_crc_err_fifo_pop_err_rsp_code_next    (o_code),
    .o_crc_err_fifo_data0_poly_lsb_next      (o_poly_lsb),
    .o_crc_err_fifo_data1_poly_msb_next      (o_poly_msb),
    .o_crc_err_fifo_data2_data_addr_next     (o_data_addr),
    .o_crc_err_fifo_data3_crc_addr_next      (o_crc_addr),
    .o_crc_err_fifo_data4_poly_size_sel_next (o_size_sel),
    .o_crc_err_fifo_data4_rpt_num_next       (o_rpt_num),
    .o_crc_err_fifo_data4_crc_req_id_next    (o_req_id),
    .o_crc_err_fifo_pop_valid_wr_enable      (o_strobe),
    .i_crc_err_fifo_pop_pop                  (pop),
    .o_err_fifo_pop_clr                      (o_clr),
    .o_crc_err_rsp_full_int_lvl              (o_full),
    .o_count                                 (o_count)
  );

  assign got = {o_code, o_poly_lsb, o_poly_msb, o_data_addr, o_crc_addr,
                o_size_sel, o_rpt_num, o_req_id};

  // Reference model: every accepted record joins the tail of exp_q.
  always @(posedge i_sys_clk) begin
    if (i_sys_arstn && push_valid && o_push_ready) begin
      exp_q.push_back(push_data);
      n_push++;
    end
  end

  // Scoreboard: each load strobe must present the oldest outstanding record.
  always @(negedge i_sys_clk) begin
    if (i_sys_arstn && o_strobe === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL load_without_record got=%h", got);
      end else begin
        exp_rec = exp_q.pop_front();
        if (got !== exp_rec) begin
          n_fail++;
          $display("FAIL load_order got=%h exp=%h", got, exp_rec);
        end
      end
      n_load++;
    end
    if (i_sys_arstn && o_clr === 1'b1) n_clr++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  function automatic crc_err_rec_t rand_rec();
    crc_err_rec_t r;
    r.err_rsp_code  = ERR_CODE_W'($urandom);
    r.poly_lsb      = $urandom;
    r.poly_msb      = $urandom;
    r.data_addr     = $urandom;
    r.crc_addr      = $urandom;
    r.poly_size_sel = SIZE_SEL_W'($urandom);
    r.rpt_num       = RPT_NUM_W'($urandom);
    r.req_id        = REQ_ID_W'($urandom);
    return r;
  endfunction

  task automatic tick();
    @(posedge i_sys_clk);
    #1;
  endtask

  task automatic apply_reset();
    i_sys_arstn = 1'b0;
    push_valid  = 1'b0;
    pop         = 1'b0;
    repeat (2) @(posedge i_sys_clk);
    #1;
    exp_q.delete();
    n_push = 0;
    n_load = 0;
    n_clr  = 0;
    i_sys_arstn = 1'b1;
  endtask

  task automatic push_one(input crc_err_rec_t rec);
    int start;
    bit ok;
    start      = n_push;
    push_data  = rec;
    push_valid = 1'b1;
    ok         = 1'b0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (n_push != start) begin
        ok = 1'b1;
        break;
      end
    end
    push_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout got=no_handshake exp=handshake");
    end
  endtask

  // Raises POP in WAIT_POP; the clear strobe is required on the second falling edge.
  task automatic do_pop(input string tag);
    int waited;
    bit seen;
    repeat (3) tick();
    pop  = 1'b1;
    seen = 1'b0;
    for (waited = 1; waited <= 8; waited++) begin
      @(negedge i_sys_clk);
      if (o_clr === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!seen || waited != 2) begin
      n_fail++;
      $display("FAIL %s pop_clr_latency got=%0d exp=2 seen=%0b", tag, waited, seen);
    end
    tick();
    pop = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 2*DEPTH+4 && n_clr < n_push; i++) do_pop(tag);
    repeat (4) tick();
    n_checks++;
    if (n_load != n_push || n_clr != n_push) begin
      n_fail++;
      $display("FAIL %s drain_counts got=load%0d/clr%0d exp=%0d", tag, n_load, n_clr, n_push);
    end
    n_checks++;
    if (exp_q.size() != 0 || o_count !== CW'(0)) begin
      n_fail++;
      $display("FAIL %s drain_empty got=model%0d/count%0d exp=0", tag, exp_q.size(), o_count);
    end
  endtask

  task automatic test_reset();
    i_sys_arstn = 1'b0;
    push_valid  = 1'b0;
    pop         = 1'b0;
    push_data   = rand_rec();
    repeat (2) @(posedge i_sys_clk);
    @(negedge i_sys_clk);
    n_checks++;
    if (o_push_ready !== 1'b1 || o_count !== CW'(0)) begin
      n_fail++;
      $display("FAIL reset_ready_count got=%b/%0d exp=1/0", o_push_ready, o_count);
    end
    n_checks++;
    if (o_strobe !== 1'b0 || o_clr !== 1'b0 || o_full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_strobes got=%b%b%b exp=000", o_strobe, o_clr, o_full);
    end
    n_checks++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL reset_presented got=%h exp=0", got);
    end
    apply_reset();
  endtask

  task automatic test_single();
    crc_err_rec_t r;
    apply_reset();
    r = rand_rec();
    r.err_rsp_code = 8'h5A;
    r.req_id       = 16'h1234;
    push_one(r);
    @(negedge i_sys_clk);
    n_checks++;
    if (o_strobe !== 1'b0 || o_count !== CW'(1)) begin
      n_fail++;
      $display("FAIL single_cycle1 got=strobe%b/count%0d exp=0/1", o_strobe, o_count);
    end
    @(negedge i_sys_clk);
    n_checks++;
    if (o_strobe !== 1'b1 || o_count !== CW'(0)) begin
      n_fail++;
      $display("FAIL single_cycle2 got=strobe%b/count%0d exp=1/0", o_strobe, o_count);
    end
    n_checks++;
    if (got !== r) begin
      n_fail++;
      $display("FAIL single_fields got=%h exp=%h", got, r);
    end
    @(negedge i_sys_clk);
    n_checks++;
    if (o_strobe !== 1'b0) begin
      n_fail++;
      $display("FAIL single_one_cycle_strobe got=%b exp=0", o_strobe);
    end
    drain("single");
    n_checks++;
    if (got !== r) begin
      n_fail++;
      $display("FAIL single_hold_idle got=%h exp=%h", got, r);
    end
  endtask

  task automatic test_fill();
    apply_reset();
    for (int i = 0; i < DEPTH+1; i++) push_one(rand_rec());
    @(negedge i_sys_clk);
    n_checks++;
    if (o_count !== CW'(DEPTH) || o_full !== 1'b1 || o_push_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full got=count%0d/full%b/ready%b exp=%0d/1/0", o_count, o_full, o_push_ready, DEPTH);
    end
    tick();
    push_data  = rand_rec();
    push_valid = 1'b1;
    repeat (5) tick();
    n_checks++;
    if (n_push != DEPTH+1 || n_load != 1) begin
      n_fail++;
      $display("FAIL fill_stall got=push%0d/load%0d exp=%0d/1", n_push, n_load, DEPTH+1);
    end
    do_pop("fill");
    @(negedge i_sys_clk);
    n_checks++;
    if (o_full !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_full_before_load got=%b exp=1", o_full);
    end
    @(negedge i_sys_clk);
    n_checks++;
    if (o_full !== 1'b0 || o_push_ready !== 1'b1 || o_count !== CW'(DEPTH-1)) begin
      n_fail++;
      $display("FAIL fill_after_load got=full%b/ready%b/count%0d exp=0/1/%0d", o_full, o_push_ready, o_count, DEPTH-1);
    end
    tick();
    push_valid = 1'b0;
    n_checks++;
    if (n_push != DEPTH+2) begin
      n_fail++;
      $display("FAIL fill_tenth_push got=%0d exp=%0d", n_push, DEPTH+2);
    end
    drain("fill");
  endtask

  task automatic test_pop_hold();
    int c0, l0;
    apply_reset();
    push_one(rand_rec());
    push_one(rand_rec());
    repeat (4) tick();
    c0  = n_clr;
    l0  = n_load;
    pop = 1'b1;
    repeat (5) tick();
    pop = 1'b0;
    repeat (6) tick();
    n_checks++;
    if (n_clr != c0 + 1 || n_load != l0 + 1) begin
      n_fail++;
      $display("FAIL pop_hold got=clr+%0d/load+%0d exp=+1/+1", n_clr - c0, n_load - l0);
    end
    drain("hold");
  endtask

  task automatic test_idle_pop();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      pop = 1'b1;
      @(negedge i_sys_clk);
      n_checks++;
      if (o_clr !== 1'b0 || o_strobe !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_toggle got=clr%b/strobe%b exp=0/0", o_clr, o_strobe);
      end
      tick();
      pop = 1'b0;
      tick();
    end
    n_checks++;
    if (n_clr != 0 || n_load != 0 || o_count !== CW'(0)) begin
      n_fail++;
      $display("FAIL idle_no_effect got=clr%0d/load%0d/count%0d exp=0/0/0", n_clr, n_load, o_count);
    end
    pop = 1'b1;
    tick();
    push_one(rand_rec());
    repeat (6) tick();
    n_checks++;
    if (n_load != 1 || n_clr != 0) begin
      n_fail++;
      $display("FAIL idle_edge_discarded got=load%0d/clr%0d exp=1/0", n_load, n_clr);
    end
    pop = 1'b0;
    drain("idle");
  endtask

  task automatic test_wrap_same_edge();
    apply_reset();
    for (int i = 0; i < DEPTH-1; i++) push_one(rand_rec());
    @(negedge i_sys_clk);
    n_checks++;
    if (o_count !== CW'(DEPTH-2)) begin
      n_fail++;
      $display("FAIL wrap_prefill got=%0d exp=%0d", o_count, DEPTH-2);
    end
    repeat (3) do_pop("wrap");
    repeat (3) tick();
    n_checks++;
    if (o_count !== CW'(3)) begin
      n_fail++;
      $display("FAIL wrap_count3 got=%0d exp=3", o_count);
    end
    do_pop("wrap");
    push_one(rand_rec());
    @(negedge i_sys_clk);
    n_checks++;
    if (o_strobe !== 1'b1 || o_count !== CW'(3)) begin
      n_fail++;
      $display("FAIL wrap_same_edge got=strobe%b/count%0d exp=1/3", o_strobe, o_count);
    end
    tick();
    for (int i = 0; i < 3; i++) push_one(rand_rec());
    drain("wrap");
  endtask

  task automatic test_random();
    localparam int N = 24;
    apply_reset();
    fork
      begin
        for (int i = 0; i < N; i++) begin
          repeat ($urandom_range(0, 3)) tick();
          push_one(rand_rec());
        end
      end
      begin
        for (int k = 0; k < N; k++) begin
          for (int c = 0; c < 400 && !(n_load > n_clr); c++) tick();
          repeat ($urandom_range(0, 4)) tick();
          do_pop("random");
        end
      end
    join
    repeat (4) tick();
    n_checks++;
    if (n_load != N || n_clr != N || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL random_totals got=load%0d/clr%0d/left%0d exp=%0d/%0d/0", n_load, n_clr, exp_q.size(), N, N);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 6; i++) push_one(rand_rec());
    do_pop("rstmid");
    tick();
    @(negedge i_sys_clk);
    n_checks++;
    if (o_strobe !== 1'b1 || o_count !== CW'(4)) begin
      n_fail++;
      $display("FAIL rstmid_in_load got=strobe%b/count%0d exp=1/4", o_strobe, o_count);
    end
    i_sys_arstn = 1'b0;
    @(negedge i_sys_clk);
    n_checks++;
    if (o_strobe !== 1'b0 || o_clr !== 1'b0 || o_full !== 1'b0 ||
        o_push_ready !== 1'b1 || o_count !== CW'(0) || got !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs got=strobe%b/clr%b/full%b/ready%b/count%0d/rec%h exp=0/0/0/1/0/0",
               o_strobe, o_clr, o_full, o_push_ready, o_count, got);
    end
    tick();
    exp_q.delete();
    n_push = 0;
    n_load = 0;
    n_clr  = 0;
    i_sys_arstn = 1'b1;
    repeat (8) tick();
    n_checks++;
    if (n_load != 0 || o_count !== CW'(0)) begin
      n_fail++;
      $display("FAIL rstmid_abandoned got=load%0d/count%0d exp=0/0", n_load, o_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_pop_hold();
    test_idle_pop();
    test_wrap_same_edge();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
